chain_sequencer: RTL
====================

CHAIN_SEQUENCER -- requirements
Module: chain_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- N, 8, vector lanes
- DATA_WIDTH, 32, bits per lane
- MAX_CHAINS, 4, maximum chains per vector
- PERSONAL_CONFIG_ID, 0, configId value addressing this block
- INITIAL_NUM_CHAINS, 1, chains active after reset (1..MAX_CHAINS)

REQ-002 Ports SHALL be, one per line: name  direction  width  meaning:
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- tracing  in  1  global trace enable
- configId  in  8  config bus target
- configData  in  8  config bus payload
- valid_in  in  1  upstream vector valid
- ready_in  out  1  block accepts vector this cycle
- eof_in  in  1  end-of-frame tag of input vector
- vector_in  in  N x DATA_WIDTH  input vector
- vector_out  out  N x DATA_WIDTH  vector issued to filter-reduce datapath
- chainId_out  out  $clog2(MAX_CHAINS)  chain being issued
- valid_out  out  1  issue beat valid
- eof_out  out  1  eof tag of issued beat
- busy  out  1  state is ISSUE

REQ-003 The design SHALL use one clock, clk; reset is rst_n, synchronous, active-low.

Function
REQ-004 The block SHALL replicate each accepted vector once per active chain, issuing chainIds 0..num_chains-1 in ascending order, one per cycle.
REQ-005 State machine SHALL have two states:
- IDLE: accept on valid_in && ready_in, then go to ISSUE
- ISSUE: after the final beat, go to IDLE, or stay in ISSUE if a new vector is accepted that cycle
REQ-006 ready_in SHALL be combinational: tracing && (state==IDLE || (state==ISSUE && cnt==num_chains-1)).
REQ-007 On accept, the block SHALL capture vector_in and eof_in into holding registers and set cnt=0.
REQ-008 Latency SHALL be one cycle: accept in cycle t gives the first beat (chainId 0) in cycle t+1.
REQ-009 Back-to-back accepts SHALL sustain one vector per num_chains cycles with no bubble.
REQ-010 vector_out, chainId_out, eof_out and valid_out SHALL be registered.
REQ-011 In ISSUE with tracing=1: valid_out=1, chainId_out=cnt, vector_out=held vector, eof_out=held eof on every beat.
REQ-012 In ISSUE with tracing=0: valid_out SHALL be 0 and cnt and held data SHALL freeze; the sequence SHALL resume at the same cnt when tracing returns to 1.
REQ-013 In IDLE, valid_out SHALL be 0 and vector_out, chainId_out and eof_out SHALL hold their last values.
REQ-014 The downstream interface SHALL have no backpressure; every beat with valid_out=1 is consumed.
REQ-015 A config write SHALL occur on any cycle with configId==PERSONAL_CONFIG_ID.
REQ-016 For a config write, configData values 1..MAX_CHAINS SHALL be valid and all other values SHALL be ignored (no state change).
REQ-017 A valid config write in IDLE SHALL update num_chains on the next cycle.
REQ-018 A valid config write during ISSUE SHALL be stored in a pending register and applied when the current vector's final beat issues; a vector accepted in that same cycle SHALL use the new num_chains.
REQ-019 Multiple pending writes SHALL resolve last-writer-wins.
REQ-020 A config write coincident with an accept in IDLE SHALL apply to the accepted vector.
REQ-021 With num_chains=1, every beat SHALL be final; the block SHALL pass one vector per cycle with chainId_out=0.
REQ-022 cnt SHALL never exceed num_chains-1 and SHALL wrap to 0 only through a new accept.
REQ-023 busy SHALL be 1 exactly when state==ISSUE.

Reset
REQ-024 While rst_n=0 at posedge, the block SHALL set: state=IDLE, cnt=0, valid_out=0, eof_out=0, chainId_out=0, vector_out all lanes 0, num_chains=INITIAL_NUM_CHAINS, pending cleared, held vector/eof cleared.
REQ-025 Reset mid-ISSUE SHALL abandon the remaining beats; valid_out=0 in the cycle after reset is sampled.
REQ-026 Reset SHALL take priority over config writes and accepts in the same cycle.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset, configData=3 to PERSONAL_CONFIG_ID, one vector (lanes 1..8, eof=1) -> beats chainId 0,1,2 in cycles t+1..t+3, all eof_out=1, ready_in low during cycles t+1,t+2.
- num_chains=4, valid_in held high with 3 vectors -> 12 consecutive valid beats, chainId 0,1,2,3 repeating, no bubbles.
- num_chains=2, configData=4 written mid-ISSUE -> current vector issues 2 beats, next vector issues 4 beats; configData=0 or 9 -> num_chains unchanged.
- num_chains=4, tracing dropped after chainId 1 for 3 cycles -> valid_out=0 for 3 cycles, then chainId 2,3 issue; no accept while tracing=0.
- rst_n low during chainId 1 of 4 -> valid_out=0 next cycle, num_chains=INITIAL_NUM_CHAINS, ready_in=1 after release.
- num_chains=1 with continuous input -> one beat per cycle, chainId_out=0, busy stays high.

Source files
------------

// File: rtl/chain_sequencer.sv
// ---------------------------------------------------------------------------
// chain_sequencer
//
// Purpose:
//    Accepts one N-lane vector at a time and re-issues it once per active
//    chain. Beats carry chainId 0..num_chains-1 in ascending order, one per
//    cycle. The number of active chains is set over a small config bus.
//    A write that arrives mid-vector is parked and only takes effect once
//    that vector has finished issuing.
//
// Ports:
//    clk          - single clock, all logic on posedge
//    rst_n        - synchronous active-low reset
//    tracing      - global enable; gates both accepts and beat issue
//    configId     - config bus target id
//    configData   - config bus payload (new chain count, 1..MAX_CHAINS)
//    valid_in     - upstream vector valid
//    ready_in     - block accepts a vector this cycle (combinational)
//    eof_in       - end-of-frame tag of the input vector
//    vector_in    - input vector, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//    vector_out   - vector issued to the filter-reduce datapath
//    chainId_out  - chain being issued
//    valid_out    - issue beat valid (no downstream backpressure)
//    eof_out      - eof tag of the issued beat
//    busy         - high while a vector is being issued
// ---------------------------------------------------------------------------
module chain_sequencer #(
   parameter int N                  = 8,
   parameter int DATA_WIDTH         = 32,
   parameter int MAX_CHAINS         = 4,
   parameter int PERSONAL_CONFIG_ID = 0,
   parameter int INITIAL_NUM_CHAINS = 1,
   localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1,
   localparam int NW = $clog2(MAX_CHAINS + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      tracing,
   input  logic [7:0]                configId,
   input  logic [7:0]                configData,
   input  logic                      valid_in,
   output logic                      ready_in,
   input  logic                      eof_in,
   input  logic [N*DATA_WIDTH-1:0]   vector_in,
   output logic [N*DATA_WIDTH-1:0]   vector_out,
   output logic [CW-1:0]             chainId_out,
   output logic                      valid_out,
   output logic                      eof_out,
   output logic                      busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_e;

   localparam logic [7:0] CFG_ID  = 8'(PERSONAL_CONFIG_ID);
   localparam logic [7:0] CFG_MAX = 8'(MAX_CHAINS);

   state_e                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [NW-1:0]            numChains_q, numChains_d;
   logic                     pendValid_q, pendValid_d;
   logic [NW-1:0]            pendNum_q, pendNum_d;
   logic                     validOut_q, validOut_d;
   logic                     eofOut_q, eofOut_d;
   logic [CW-1:0]            chainOut_q, chainOut_d;
   logic [N*DATA_WIDTH-1:0]  vectorOut_q, vectorOut_d;

   logic                     cfgWrite;
   logic [NW-1:0]            cfgNum;
   logic                     isLast;
   logic                     accept;
   logic                     finishing;
   logic                     advancing;

   // Decode the config bus and classify this cycle. The final beat of a
   // vector is the one showing cnt == num_chains-1. The vector only counts
   // as finished when tracing lets the sequence move past that beat. That
   // same cycle is the one where a new vector may be accepted.
   always_comb begin
      cfgWrite  = (configId == CFG_ID) && (configData >= 8'd1) && (configData <= CFG_MAX);
      cfgNum    = NW'(configData);
      isLast    = (NW'(cnt_q) == (numChains_q - NW'(1)));
      ready_in  = tracing && ((state_q == IDLE) || ((state_q == ISSUE) && isLast));
      accept    = valid_in && ready_in;
      finishing = (state_q == ISSUE) && tracing && isLast;
      advancing = (state_q == ISSUE) && tracing && !isLast;
   end

   // Next-state logic. The output registers also act as the holding
   // registers for the accepted vector and eof. They load on accept and
   // then hold for every later beat, so no separate copy is kept. valid_out
   // defaults low, which covers IDLE, a frozen ISSUE (tracing=0) and the
   // cycle after the last beat. A pending chain count is applied at the end
   // of the final beat, ahead of a back-to-back accept, so the new vector
   // already counts against it.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      numChains_d = numChains_q;
      pendValid_d = pendValid_q;
      pendNum_d   = pendNum_q;
      validOut_d  = 1'b0;
      eofOut_d    = eofOut_q;
      chainOut_d  = chainOut_q;
      vectorOut_d = vectorOut_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (finishing && !accept) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (accept) begin
         cnt_d       = '0;
         validOut_d  = 1'b1;
         chainOut_d  = '0;
         vectorOut_d = vector_in;
         eofOut_d    = eof_in;
      end else if (advancing) begin
         cnt_d      = cnt_q + CW'(1);
         validOut_d = 1'b1;
         chainOut_d = cnt_q + CW'(1);
      end

      if (cfgWrite && ((state_q == IDLE) || finishing)) begin
         numChains_d = cfgNum;
         pendValid_d = 1'b0;
      end else if (finishing && pendValid_q) begin
         numChains_d = pendNum_q;
         pendValid_d = 1'b0;
      end else if (cfgWrite) begin
         pendValid_d = 1'b1;
         pendNum_d   = cfgNum;
      end
   end

   // State and output registers. Reset wins over any accept or config
   // write in the same cycle, and it drops any beats still to be issued.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         numChains_q <= NW'(INITIAL_NUM_CHAINS);
         pendValid_q <= 1'b0;
         pendNum_q   <= '0;
         validOut_q  <= 1'b0;
         eofOut_q    <= 1'b0;
         chainOut_q  <= '0;
         vectorOut_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         numChains_q <= numChains_d;
         pendValid_q <= pendValid_d;
         pendNum_q   <= pendNum_d;
         validOut_q  <= validOut_d;
         eofOut_q    <= eofOut_d;
         chainOut_q  <= chainOut_d;
         vectorOut_q <= vectorOut_d;
      end
   end

   assign vector_out  = vectorOut_q;
   assign chainId_out = chainOut_q;
   assign valid_out   = validOut_q;
   assign eof_out     = eofOut_q;
   assign busy        = (state_q == ISSUE);

endmodule
